// File: rtl/nano_cpu_pkg.sv
// Shared types and constants for the nano CPU: opcodes, FSM states and IR field positions.
// No configuration macros are used here.
package nano_cpu_pkg;

    localparam int IR_W     = 16;
    localparam int OPC_LSB  = 12;
    localparam int ADDR_LSB = 4;
    localparam int RD_LSB   = 8;
    localparam int RS1_LSB  = 4;
    localparam int RT_LSB   = 0;
    localparam int REG_AW   = 2;

    typedef enum logic [3:0] {
        OP_READ   = 4'd0,
        OP_WRITE  = 4'd1,
        OP_JMP    = 4'd2,
        OP_BRANCH = 4'd3,
        OP_XOR    = 4'd4,
        OP_SUB    = 4'd5,
        OP_ADD    = 4'd6,
        OP_LESS   = 4'd7,
        OP_END    = 4'd8
    } opcode_e;

    typedef enum logic [3:0] {
        S_IDLE,
        S_FETCH,
        S_EXEC,
        S_LD,
        S_WRITE,
        S_ALU,
        S_JMP,
        S_BRANCH,
        S_HALT
    } state_e;

endpackage

// File: rtl/nano_regfile.sv
// NREG x DW register file: one write port, three combinational read ports, async clear.
module nano_regfile
    import nano_cpu_pkg::*;
#(
    parameter int DW   = 16,
    parameter int NREG = 4
) (
    input  logic              ck,
    input  logic              rst,
    input  logic              we_i,
    input  logic [REG_AW-1:0] waddr_i,
    input  logic [DW-1:0]     wdata_i,
    input  logic [REG_AW-1:0] raddr0_i,
    input  logic [REG_AW-1:0] raddr1_i,
    input  logic [REG_AW-1:0] raddr2_i,
    output logic [DW-1:0]     rdata0_o,
    output logic [DW-1:0]     rdata1_o,
    output logic [DW-1:0]     rdata2_o
);

    logic [DW-1:0] regs_q [NREG];

    always_ff @(posedge ck or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we_i) begin
            regs_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata0_o = regs_q[raddr0_i];
    assign rdata1_o = regs_q[raddr1_i];
    assign rdata2_o = regs_q[raddr2_i];

endmodule

// File: rtl/nano_cpu_gen2.sv
// Multi-cycle 16-bit-instruction CPU with a single ce/we/mem_rdy memory port.
// Macro NANO_CPU_SIGNED_LESS_EN makes LESS a signed compare (unsigned otherwise).
module nano_cpu_gen2
    import nano_cpu_pkg::*;
#(
    parameter int DW   = 16,
    parameter int AW   = 8,
    parameter int NREG = 4
) (
    input  logic          ck,
    input  logic          rst,
    output logic [AW-1:0] address,
    input  logic [DW-1:0] dataR,
    output logic [DW-1:0] dataW,
    output logic          ce,
    output logic          we,
    input  logic          mem_rdy,
    output logic          halted,
    output state_e        dbg_state_o
);

    if (NREG != 4) begin : g_bad_nreg
        $error("nano_cpu_gen2: NREG must be 4");
    end
    if (DW < 16 || DW > 32 || AW < 4 || AW > 8) begin : g_bad_width
        $error("nano_cpu_gen2: DW must be 16..32 and AW 4..8");
    end

    state_e              state_q, state_d;
    logic [AW-1:0]       pc_q, pc_d, pc_inc, addr_f;
    logic [IR_W-1:0]     ir_q, ir_d;
    logic [3:0]          opc;
    logic [REG_AW-1:0]   rd, rs1, rt;
    logic [DW-1:0]       rs1_val, rs2_val, rt_val, alu_res;
    logic                lt;
    logic                rf_we;
    logic [REG_AW-1:0]   rf_waddr;
    logic [DW-1:0]       rf_wdata;
    logic                unused_ir;

    assign opc       = ir_q[OPC_LSB +: 4];
    assign addr_f    = ir_q[ADDR_LSB +: AW];
    assign rd        = ir_q[RD_LSB +: REG_AW];
    assign rs1       = ir_q[RS1_LSB +: REG_AW];
    assign rt        = ir_q[RT_LSB +: REG_AW];
    assign pc_inc    = pc_q + AW'(1);
    assign unused_ir = ^ir_q;

    // rs2 and rt share IR[1:0]; they get separate read ports to keep ALU and memory paths apart.
    nano_regfile #(.DW(DW), .NREG(NREG)) u_regfile (
        .ck       (ck),
        .rst      (rst),
        .we_i     (rf_we),
        .waddr_i  (rf_waddr),
        .wdata_i  (rf_wdata),
        .raddr0_i (rs1),
        .raddr1_i (rt),
        .raddr2_i (rt),
        .rdata0_o (rs1_val),
        .rdata1_o (rs2_val),
        .rdata2_o (rt_val)
    );

`ifdef NANO_CPU_SIGNED_LESS_EN
    assign lt = $signed(rs1_val) < $signed(rs2_val);
`else
    assign lt = rs1_val < rs2_val;
`endif

    always_comb begin
        alu_res = '0;
        case (opc)
            OP_XOR:  alu_res = rs1_val ^ rs2_val;
            OP_SUB:  alu_res = rs1_val - rs2_val;
            OP_ADD:  alu_res = rs1_val + rs2_val;
            default: alu_res = {{(DW-1){1'b0}}, lt};
        endcase
    end

    always_ff @(posedge ck or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
        end
    end

    // Outputs depend on state only, never on mem_rdy, so the memory sees a stable request.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ir_d     = ir_q;
        ce       = 1'b0;
        we       = 1'b0;
        address  = '0;
        dataW    = '0;
        rf_we    = 1'b0;
        rf_waddr = rt;
        rf_wdata = dataR;
        case (state_q)
            S_IDLE: state_d = S_FETCH;
            S_FETCH: begin
                ce      = 1'b1;
                address = pc_q;
                if (mem_rdy) begin
                    ir_d    = dataR[IR_W-1:0];
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                case (opc)
                    OP_READ:                         state_d = S_LD;
                    OP_WRITE:                        state_d = S_WRITE;
                    OP_JMP:                          state_d = S_JMP;
                    OP_BRANCH:                       state_d = S_BRANCH;
                    OP_XOR, OP_SUB, OP_ADD, OP_LESS: state_d = S_ALU;
                    default:                         state_d = S_HALT;
                endcase
            end
            S_LD: begin
                ce      = 1'b1;
                address = addr_f;
                if (mem_rdy) begin
                    rf_we   = 1'b1;
                    pc_d    = pc_inc;
                    state_d = S_FETCH;
                end
            end
            S_WRITE: begin
                ce      = 1'b1;
                we      = 1'b1;
                address = addr_f;
                dataW   = rt_val;
                if (mem_rdy) begin
                    pc_d    = pc_inc;
                    state_d = S_FETCH;
                end
            end
            S_ALU: begin
                rf_we    = 1'b1;
                rf_waddr = rd;
                rf_wdata = alu_res;
                pc_d     = pc_inc;
                state_d  = S_FETCH;
            end
            S_JMP: begin
                pc_d    = addr_f;
                state_d = S_FETCH;
            end
            S_BRANCH: begin
                pc_d    = (rt_val != '0) ? addr_f : pc_inc;
                state_d = S_FETCH;
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_IDLE;
        endcase
    end

    assign halted      = (state_q == S_HALT);
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_nano_cpu_gen2.sv
// Bench for nano_cpu_gen2: an instruction-level model predicts every memory access,
// which is compared on each ce cycle; directed programs cover latency, wrap, branch and halt.
module tb_nano_cpu_gen2;
    import nano_cpu_pkg::*;

    localparam int DW = 16;
    localparam int AW = 8;

    logic          ck      = 1'b0;
    logic          rst     = 1'b1;
    logic [AW-1:0] address;
    logic [DW-1:0] dataR   = '0;
    logic [DW-1:0] dataW;
    logic          ce;
    logic          we;
    logic          mem_rdy = 1'b0;
    logic          halted;
    state_e        dbg_state;

    nano_cpu_gen2 #(.DW(DW), .AW(AW), .NREG(4)) dut (
        .ck          (ck),
        .rst         (rst),
        .address     (address),
        .dataR       (dataR),
        .dataW       (dataW),
        .ce          (ce),
        .we          (we),
        .mem_rdy     (mem_rdy),
        .halted      (halted),
        .dbg_state_o (dbg_state)
    );

    always #5 ck = ~ck;

    logic [15:0] mem     [256];
    logic [15:0] ref_mem [256];
    logic [31:0] exp_q   [$];
    int          hs_cyc  [$];
    logic [7:0]  hs_addr [$];
    int          stall_q [$];
    bit          rand_rdy;
    bit          halted_exp;
    int          n_checks = 0;
    int          n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] acc(input logic w, input logic [7:0] a, input logic [15:0] d);
        return {7'b0, w, a, d};
    endfunction

    function automatic int next_stall();
        if (stall_q.size() > 0) return stall_q.pop_front();
        return rand_rdy ? int'($urandom_range(0, 2)) : 0;
    endfunction

    // ISA-level model: runs up to k instructions from the current memory image.
    task automatic build_expect(input int k);
        logic [15:0] regs [4];
        logic [7:0]  pc, a;
        logic [15:0] ins;
        logic [1:0]  rd, rs1, rt;
        for (int i = 0; i < 4; i++) regs[i] = '0;
        for (int i = 0; i < 256; i++) ref_mem[i] = mem[i];
        exp_q.delete();
        pc = '0;
        halted_exp = 1'b0;
        for (int i = 0; i < k && !halted_exp; i++) begin
            ins = ref_mem[pc];
            a   = ins[11:4];
            rd  = ins[9:8];
            rs1 = ins[5:4];
            rt  = ins[1:0];
            exp_q.push_back(acc(1'b0, pc, 16'h0));
            case (ins[15:12])
                4'd0: begin exp_q.push_back(acc(1'b0, a, 16'h0)); regs[rt] = ref_mem[a]; pc = pc + 8'd1; end
                4'd1: begin exp_q.push_back(acc(1'b1, a, regs[rt])); ref_mem[a] = regs[rt]; pc = pc + 8'd1; end
                4'd2: pc = a;
                4'd3: pc = (regs[rt] != 0) ? a : pc + 8'd1;
                4'd4: begin regs[rd] = regs[rs1] ^ regs[rt]; pc = pc + 8'd1; end
                4'd5: begin regs[rd] = regs[rs1] - regs[rt]; pc = pc + 8'd1; end
                4'd6: begin regs[rd] = regs[rs1] + regs[rt]; pc = pc + 8'd1; end
                4'd7: begin
`ifdef NANO_CPU_SIGNED_LESS_EN
                    regs[rd] = ($signed(regs[rs1]) < $signed(regs[rt])) ? 16'd1 : 16'd0;
`else
                    regs[rd] = (regs[rs1] < regs[rt]) ? 16'd1 : 16'd0;
`endif
                    pc = pc + 8'd1;
                end
                default: halted_exp = 1'b1;
            endcase
        end
    endtask

    task automatic do_reset();
        @(negedge ck);
        rst     = 1'b1;
        mem_rdy = 1'b0;
        #1;
        check("rst_out", {7'b0, ce, we, halted, address, dataW}, 32'h0);
        repeat (2) @(negedge ck);
        rst = 1'b0;
    endtask

    task automatic run_prog(input int k);
        int cyc;
        int stall_left;
        int nbad;
        build_expect(k);
        hs_cyc.delete();
        hs_addr.delete();
        do_reset();
        stall_left = next_stall();
        cyc = 0;
        while (exp_q.size() > 0 && cyc < 3000) begin
            @(negedge ck);
            cyc++;
            mem_rdy = 1'b0;
            dataR   = 16'($urandom);
            if (ce) begin
                check("access", {7'b0, we, address, dataW}, exp_q[0]);
                if (stall_left > 0) begin
                    stall_left--;
                end else begin
                    mem_rdy = 1'b1;
                    dataR   = mem[address];
                    if (we) mem[address] = dataW;
                    hs_cyc.push_back(cyc);
                    hs_addr.push_back(address);
                    void'(exp_q.pop_front());
                    stall_left = next_stall();
                end
            end else begin
                mem_rdy = 1'($urandom_range(0, 1));
            end
        end
        check("drain", exp_q.size(), 0);
        nbad = 0;
        for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) nbad++;
        check("mem_image", nbad, 0);
        @(negedge ck);
        mem_rdy = 1'b0;
        @(negedge ck);
        if (halted_exp) begin
            for (int i = 0; i < 3; i++) begin
                @(negedge ck);
                mem_rdy = 1'($urandom_range(0, 1));
                check("halt", {30'b0, halted, ce}, 32'h2);
            end
        end
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = 16'hF000;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rand_rdy = 1'b0;

        // READ R1<-mem[5], WRITE R1->mem[0x10], END; mem_rdy always high
        clear_mem();
        mem[0] = 16'h0051; mem[1] = 16'h1101; mem[5] = 16'h1234;
        run_prog(10);
        check("lat_fast", hs_cyc[2], 4);
        check("ld_r1", mem[8'h10], 16'h1234);

        // same program, FETCH stalled 4 cycles and LD stalled 2
        clear_mem();
        mem[0] = 16'h0051; mem[1] = 16'h1101; mem[5] = 16'h1234;
        stall_q = '{4, 2};
        run_prog(10);
        check("lat_stall", hs_cyc[2], 10);
        check("ld_r1_stall", mem[8'h10], 16'h1234);

        // R1=1, R2=2, SUB R3=R1-R2, LESS R0=R1<R3, store R3 and R0
        clear_mem();
        mem[0] = 16'h0401; mem[1] = 16'h0412; mem[2] = 16'h5312; mem[3] = 16'h7013;
        mem[4] = 16'h1503; mem[5] = 16'h1510; mem[8'h40] = 16'h0001; mem[8'h41] = 16'h0002;
        run_prog(20);
        check("sub_wrap", mem[8'h50], 16'hFFFF);
`ifdef NANO_CPU_SIGNED_LESS_EN
        check("less", mem[8'h51], 16'h0000);
`else
        check("less", mem[8'h51], 16'h0001);
`endif

        // BRANCH R0 to 0x20 with R0=0
        clear_mem();
        mem[0] = 16'h3200;
        run_prog(10);
        check("br_not_taken", hs_addr[1], 8'h01);

        // BRANCH R0 to 0x20 with R0=7
        clear_mem();
        mem[0] = 16'h0400; mem[1] = 16'h3200; mem[8'h40] = 16'h0007;
        run_prog(10);
        check("br_taken", hs_addr[3], 8'h20);

        // WRITE at PC=0xFF, PC wraps to 0; random memory latency
        rand_rdy = 1'b1;
        clear_mem();
        mem[0] = 16'h0302; mem[1] = 16'h2FF0; mem[8'hFF] = 16'h10A2; mem[8'h30] = 16'hBEEF;
        run_prog(4);
        check("wr_pc_ff", hs_addr[3], 8'hFF);
        check("pc_wrap", hs_addr[5], 8'h00);
        check("wr_data", mem[8'h0A], 16'hBEEF);

        // random programs with random memory latency
        for (int t = 0; t < 8; t++) begin
            for (int i = 0; i < 256; i++) begin
                if ($urandom_range(0, 19) < 2) mem[i] = 16'hF000 | 16'($urandom_range(0, 4095));
                else mem[i] = {1'b0, 3'($urandom_range(0, 7)), 12'($urandom)};
            end
            run_prog(40);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/nano_cpu_gen2.md
NANO_CPU_GEN2 -- requirements
Module: nano_cpu_gen2

Interface
REQ-001 Parameter DW, default 16: data and register width; legal values 16..32.
REQ-002 Parameter AW, default 8: memory address and PC width; legal values 4..8.
REQ-003 Parameter NREG, default 4: number of general-purpose registers; fixed at 4, and any other value SHALL fail elaboration.
REQ-004 ck  input  1: clock; all state updates on the rising edge.
REQ-005 rst  input  1: reset rst, asynchronous, active-high.
REQ-006 address  output  AW: memory address.
REQ-007 dataR  input  DW: memory read data.
REQ-008 dataW  output  DW: memory write data.
REQ-009 ce  output  1: memory access request.
REQ-010 we  output  1: write strobe, qualified by ce.
REQ-011 mem_rdy  input  1: memory completes the current access in the cycle where ce=1 and mem_rdy=1.
REQ-012 halted  output  1: high while in state HALT.

Function
REQ-013 Instruction format SHALL be IR[15:0], taken from dataR[15:0]: opcode IR[15:12], addr IR[11:4] truncated to AW bits, rd IR[9:8], rs1 IR[5:4], rs2/rt IR[1:0].
REQ-014 Opcode decode SHALL be: 0 READ (R[rt]<=mem[addr]); 1 WRITE (mem[addr]<=R[rt]); 2 JMP (PC<=addr); 3 BRANCH (PC<=addr if R[rt]!=0, else PC+1); 4 XOR; 5 SUB; 6 ADD; 7 LESS (R[rd]<=R[rs1] op R[rs2]); 8-15 END.
REQ-015 ADD and SUB SHALL wrap modulo 2^DW, with no flags.
REQ-016 LESS SHALL write 1 or 0, zero-extended to DW.
REQ-017 FSM states SHALL be IDLE, FETCH, EXEC, LD, WRITE, ALU, JMP, BRANCH, HALT.
REQ-018 FSM transitions SHALL be IDLE->FETCH; FETCH->EXEC on mem_rdy, otherwise hold.
REQ-019 From EXEC, the FSM SHALL go to LD, WRITE, JMP, BRANCH, ALU or HALT by opcode; HALT is absorbing.
REQ-020 LD and WRITE SHALL hold until mem_rdy, then go to FETCH; ALU, JMP and BRANCH SHALL go to FETCH after exactly one cycle.
REQ-021 ce SHALL be 1 only in FETCH, LD and WRITE; we SHALL be 1 only in WRITE.
REQ-022 address SHALL be PC in FETCH and IR addr in LD/WRITE; in all other states it SHALL be 0.
REQ-023 dataW SHALL be R[rt] in WRITE and 0 otherwise.
REQ-024 IR SHALL load only on the FETCH cycle with mem_rdy=1.
REQ-025 The LD register write SHALL occur only on the LD cycle with mem_rdy=1, using dataR[DW-1:0].
REQ-026 PC SHALL update (PC+1 or target) only on the final cycle of LD, WRITE, ALU, JMP or BRANCH; PC+1 SHALL wrap from 2^AW-1 to 0.
REQ-027 mem_rdy outside FETCH/LD/WRITE SHALL be ignored.
REQ-028 Minimum instruction latency with mem_rdy tied high SHALL be 3 cycles (FETCH, EXEC, execute state).
REQ-029 An ALU instruction with rd equal to rs1 or rs2 SHALL read old operand values and write the result at the end of the ALU cycle.

Reset
REQ-030 On rst, the FSM SHALL go to IDLE and PC, IR and all registers SHALL clear to 0.
REQ-031 During rst, outputs SHALL be ce=0, we=0, address=0, dataW=0, halted=0.
REQ-032 rst asserted during a LD or WRITE wait SHALL abort the access with no register or PC update.

Configuration
REQ-033 With macro NANO_CPU_SIGNED_LESS_EN defined, LESS SHALL compare two's-complement signed; without it, LESS SHALL compare unsigned.

Structure
REQ-034 Package nano_cpu_pkg SHALL hold the opcode enum, the FSM state enum, and opcode and field-position constants.
REQ-035 Sub-module nano_regfile (NREG x DW, one write port, three combinational read ports, async reset) SHALL hold the registers.

Verification
REQ-036 mem[0]=0x0051 (READ R1<-mem[5]), mem[5]=0x1234, mem_rdy high -> R1=0x1234 and PC=1 after 3 cycles.
REQ-037 Same program with mem_rdy low for 4 cycles in FETCH and 2 cycles in LD -> IR, R1 and PC unchanged until rdy, then the same result with 6 extra cycles.
REQ-038 R1=0x0001, R2=0x0002, SUB R3=R1-R2 -> R3=0xFFFF; LESS R0=R1<R3 -> R0=1 unsigned, or 0 with NANO_CPU_SIGNED_LESS_EN.
REQ-039 BRANCH R0 to 0x20 with R0=0 -> PC=old+1; with R0=7 -> PC=0x20.
REQ-040 WRITE R2 to mem[0x0A] -> ce=1, we=1, address=0x0A, dataW=R2 until rdy; instruction at PC=0xFF -> next PC=0x00.
REQ-041 END opcode 0xF000 -> halted=1 permanently and ce=0; rst pulse -> IDLE, PC=0, halted=0.
